// File: rtl/ppu_pkg.sv
// rtl/ppu_pkg.sv - shared control-bundle layout, forward-select encodings and helpers for the PPU pipeline.
package ppu_pkg;

  localparam int PPU_CTRL_W = 17;

  localparam int CTRL_MEN    = 0;
  localparam int CTRL_LO     = 1;
  localparam int CTRL_HI     = 2;
  localparam int CTRL_SE     = 3;
  localparam int CTRL_RW     = 4;
  localparam int CTRL_MSZ_LO = 5;
  localparam int CTRL_TA     = 7;
  localparam int CTRL_B      = 8;
  localparam int CTRL_RF     = 9;
  localparam int CTRL_LD     = 10;
  localparam int CTRL_ALU_LO = 11;
  localparam int CTRL_SRC_LO = 14;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  localparam logic [PPU_CTRL_W-1:0] BUBBLE = '0;

  // r0 is hardwired zero, so a stage targeting it is never a real producer
  function automatic logic writes_reg(input logic rf, input logic ld, input logic [4:0] dest);
    return (rf | ld) && (dest != 5'd0);
  endfunction

endpackage

// File: rtl/ppu_fwd_unit.sv
// rtl/ppu_fwd_unit.sv - per-operand forwarding select, youngest producing stage wins.
module ppu_fwd_unit
  import ppu_pkg::*;
(
  input  logic       ex_wr_i,
  input  logic       mem_wr_i,
  input  logic       wb_wr_i,
  input  logic [4:0] ex_dest_i,
  input  logic [4:0] mem_dest_i,
  input  logic [4:0] wb_dest_i,
  input  logic [4:0] rs_i,
  input  logic [4:0] rt_i,
  output logic [1:0] fwd_a_sel_o,
  output logic [1:0] fwd_b_sel_o
);

  function automatic logic [1:0] pick(
    input logic       ex_wr,
    input logic       mem_wr,
    input logic       wb_wr,
    input logic [4:0] ex_dest,
    input logic [4:0] mem_dest,
    input logic [4:0] wb_dest,
    input logic [4:0] src
  );
    if (ex_wr && src == ex_dest)        return FWD_EX;
    else if (mem_wr && src == mem_dest) return FWD_MEM;
    else if (wb_wr && src == wb_dest)   return FWD_WB;
    else                                return FWD_RF;
  endfunction

  always_comb begin
    fwd_a_sel_o = pick(ex_wr_i, mem_wr_i, wb_wr_i, ex_dest_i, mem_dest_i, wb_dest_i, rs_i);
    fwd_b_sel_o = pick(ex_wr_i, mem_wr_i, wb_wr_i, ex_dest_i, mem_dest_i, wb_dest_i, rt_i);
  end

endmodule

// File: rtl/ppu_pipeline_ctrl.sv
// rtl/ppu_pipeline_ctrl.sv - carries decode control through EX/MEM/WB, handles load-use stalls,
// taken-branch flushes, freeze, forwarding selects and saturating stall/flush counters.
module ppu_pipeline_ctrl
  import ppu_pkg::*;
#(
  parameter int CTRL_W = 17,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [4:0]        id_dest,
  input  logic              ex_taken,
  input  logic              freeze,
  output logic              pc_ld,
  output logic              ifid_ld,
  output logic              ifid_clr,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [CTRL_W-1:0] mem_ctrl,
  output logic [CTRL_W-1:0] wb_ctrl,
  output logic [4:0]        ex_dest,
  output logic [4:0]        mem_dest,
  output logic [4:0]        wb_dest,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  logic [CTRL_W-1:0] ex_ctrl_q, ex_ctrl_d, mem_ctrl_q, mem_ctrl_d, wb_ctrl_q, wb_ctrl_d;
  logic [4:0]        ex_dest_q, ex_dest_d, mem_dest_q, mem_dest_d, wb_dest_q, wb_dest_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic              hazard;
  logic              flush;
  logic              ex_wr, mem_wr, wb_wr;
  logic [1:0]        fwd_a_raw, fwd_b_raw;

  assign hazard = ex_ctrl_q[CTRL_LD] && (ex_dest_q != 5'd0) &&
                  ((id_uses_rs && id_rs == ex_dest_q) || (id_uses_rt && id_rt == ex_dest_q));

  // a load-use hazard suppresses the flush: the EX slot is a load, so ex_taken is spurious
  assign flush = ex_taken && !hazard && !freeze;

  assign pc_ld    = !rst_n || (!freeze && !hazard);
  assign ifid_ld  = !rst_n || (!freeze && !hazard);
  assign ifid_clr = rst_n && flush;

  // load data is not ready in EX, so an EX load is never an EX-forward source
  assign ex_wr  = writes_reg(ex_ctrl_q[CTRL_RF], ex_ctrl_q[CTRL_LD], ex_dest_q) && !ex_ctrl_q[CTRL_LD];
  assign mem_wr = writes_reg(mem_ctrl_q[CTRL_RF], mem_ctrl_q[CTRL_LD], mem_dest_q);
  assign wb_wr  = writes_reg(wb_ctrl_q[CTRL_RF], wb_ctrl_q[CTRL_LD], wb_dest_q);

  ppu_fwd_unit u_fwd (
    .ex_wr_i     (ex_wr),
    .mem_wr_i    (mem_wr),
    .wb_wr_i     (wb_wr),
    .ex_dest_i   (ex_dest_q),
    .mem_dest_i  (mem_dest_q),
    .wb_dest_i   (wb_dest_q),
    .rs_i        (id_rs),
    .rt_i        (id_rt),
    .fwd_a_sel_o (fwd_a_raw),
    .fwd_b_sel_o (fwd_b_raw)
  );

  assign fwd_a_sel = rst_n ? fwd_a_raw : FWD_RF;
  assign fwd_b_sel = rst_n ? fwd_b_raw : FWD_RF;

  always_comb begin
    ex_ctrl_d   = ex_ctrl_q;
    ex_dest_d   = ex_dest_q;
    mem_ctrl_d  = mem_ctrl_q;
    mem_dest_d  = mem_dest_q;
    wb_ctrl_d   = wb_ctrl_q;
    wb_dest_d   = wb_dest_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!freeze) begin
      ex_ctrl_d  = hazard ? CTRL_W'(BUBBLE) : id_ctrl;
      ex_dest_d  = hazard ? 5'd0 : id_dest;
      mem_ctrl_d = ex_ctrl_q;
      mem_dest_d = ex_dest_q;
      wb_ctrl_d  = mem_ctrl_q;
      wb_dest_d  = mem_dest_q;
      if (hazard && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      if (flush && !(&flush_cnt_q))  flush_cnt_d = flush_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_ctrl_q   <= '0;
      ex_dest_q   <= '0;
      mem_ctrl_q  <= '0;
      mem_dest_q  <= '0;
      wb_ctrl_q   <= '0;
      wb_dest_q   <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_ctrl_q   <= ex_ctrl_d;
      ex_dest_q   <= ex_dest_d;
      mem_ctrl_q  <= mem_ctrl_d;
      mem_dest_q  <= mem_dest_d;
      wb_ctrl_q   <= wb_ctrl_d;
      wb_dest_q   <= wb_dest_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign ex_ctrl   = ex_ctrl_q;
  assign mem_ctrl  = mem_ctrl_q;
  assign wb_ctrl   = wb_ctrl_q;
  assign ex_dest   = ex_dest_q;
  assign mem_dest  = mem_dest_q;
  assign wb_dest   = wb_dest_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_ppu_pipeline_ctrl.sv
// tb/tb_ppu_pipeline_ctrl.sv - directed scoreboard bench for ppu_pipeline_ctrl.
module tb_ppu_pipeline_ctrl;

  localparam logic [16:0] C_NOP   = 17'h00000;
  localparam logic [16:0] C_LBU   = 17'h00601;
  localparam logic [16:0] C_SUBU  = 17'h00A00;
  localparam logic [16:0] C_ADDIU = 17'h04208;
  localparam logic [16:0] C_BGTZ  = 17'h00100;

  localparam int S_PC = 0, S_IFLD = 1, S_CLR = 2, S_EXC = 3, S_MEMC = 4, S_WBC = 5;
  localparam int S_EXD = 6, S_MEMD = 7, S_WBD = 8, S_FA = 9, S_FB = 10, S_STALL = 11, S_FLUSH = 12;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [16:0] id_ctrl = '0;
  logic [4:0]  id_rs = '0, id_rt = '0, id_dest = '0;
  logic        id_uses_rs = 1'b0, id_uses_rt = 1'b0, ex_taken = 1'b0, freeze = 1'b0;
  logic        pc_ld, ifid_ld, ifid_clr;
  logic [16:0] ex_ctrl, mem_ctrl, wb_ctrl;
  logic [4:0]  ex_dest, mem_dest, wb_dest;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic [15:0] stall_cnt, flush_cnt;

  typedef struct {
    int          cyc;
    int          sig;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  ppu_pipeline_ctrl #(.CTRL_W(17), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .id_ctrl(id_ctrl), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dest(id_dest),
    .ex_taken(ex_taken), .freeze(freeze), .pc_ld(pc_ld), .ifid_ld(ifid_ld),
    .ifid_clr(ifid_clr), .ex_ctrl(ex_ctrl), .mem_ctrl(mem_ctrl), .wb_ctrl(wb_ctrl),
    .ex_dest(ex_dest), .mem_dest(mem_dest), .wb_dest(wb_dest),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string sig_name(input int s);
    case (s)
      S_PC: return "pc_ld";       S_IFLD: return "ifid_ld";   S_CLR: return "ifid_clr";
      S_EXC: return "ex_ctrl";    S_MEMC: return "mem_ctrl";  S_WBC: return "wb_ctrl";
      S_EXD: return "ex_dest";    S_MEMD: return "mem_dest";  S_WBD: return "wb_dest";
      S_FA: return "fwd_a_sel";   S_FB: return "fwd_b_sel";   S_STALL: return "stall_cnt";
      default: return "flush_cnt";
    endcase
  endfunction

  function automatic logic [31:0] get_sig(input int s);
    case (s)
      S_PC: return {31'd0, pc_ld};      S_IFLD: return {31'd0, ifid_ld};  S_CLR: return {31'd0, ifid_clr};
      S_EXC: return {15'd0, ex_ctrl};   S_MEMC: return {15'd0, mem_ctrl}; S_WBC: return {15'd0, wb_ctrl};
      S_EXD: return {27'd0, ex_dest};   S_MEMD: return {27'd0, mem_dest}; S_WBD: return {27'd0, wb_dest};
      S_FA: return {30'd0, fwd_a_sel};  S_FB: return {30'd0, fwd_b_sel};  S_STALL: return {16'd0, stall_cnt};
      default: return {16'd0, flush_cnt};
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t e;
    logic [31:0] act;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      act = get_sig(e.sig);
      checks = checks + 1;
      if (e.cyc != cyc || act !== e.val) begin
        failures = failures + 1;
        $display("FAIL %s cyc=%0d exp_cyc=%0d actual=%0h required=%0h", sig_name(e.sig), cyc, e.cyc, act, e.val);
      end
    end
  end

  task automatic drive(input logic [16:0] c, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic [4:0] dest,
                       input logic tk, input logic fz);
    @(posedge clk);
    #1;
    id_ctrl = c; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
    id_dest = dest; ex_taken = tk; freeze = fz;
  endtask

  task automatic rand_drive();
    @(posedge clk);
    #1;
    id_ctrl = 17'($urandom); id_rs = 5'($urandom); id_rt = 5'($urandom);
    id_uses_rs = 1'($urandom); id_uses_rt = 1'($urandom); id_dest = 5'($urandom);
    ex_taken = 1'($urandom); freeze = 1'($urandom);
  endtask

  task automatic expect_sig(input int s, input logic [31:0] v);
    exp_t e;
    e.cyc = cyc; e.sig = s; e.val = v;
    sb.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rand_drive();
    rand_drive();
    expect_sig(S_EXC, 0); expect_sig(S_MEMC, 0); expect_sig(S_WBC, 0);
    expect_sig(S_EXD, 0); expect_sig(S_MEMD, 0); expect_sig(S_WBD, 0);
    expect_sig(S_PC, 1); expect_sig(S_IFLD, 1); expect_sig(S_CLR, 0);
    expect_sig(S_FA, 0); expect_sig(S_FB, 0); expect_sig(S_STALL, 0); expect_sig(S_FLUSH, 0);

    // load-use: LBU r5 then SUBU reading r5
    drive(C_LBU, 0, 0, 0, 0, 5, 0, 0); rst_n = 1'b1;
    expect_sig(S_PC, 1); expect_sig(S_EXC, 0);
    drive(C_SUBU, 5, 0, 1, 0, 6, 0, 0);
    expect_sig(S_EXC, C_LBU); expect_sig(S_EXD, 5); expect_sig(S_PC, 0); expect_sig(S_IFLD, 0); expect_sig(S_STALL, 0);
    drive(C_SUBU, 5, 0, 1, 0, 6, 0, 0);
    expect_sig(S_EXC, 0); expect_sig(S_MEMC, C_LBU); expect_sig(S_MEMD, 5);
    expect_sig(S_PC, 1); expect_sig(S_FA, 2); expect_sig(S_STALL, 1);
    drive(C_NOP, 0, 0, 0, 0, 0, 0, 0);
    expect_sig(S_EXC, C_SUBU); expect_sig(S_EXD, 6); expect_sig(S_WBC, C_LBU); expect_sig(S_WBD, 5);

    // forward priority
    drive(C_ADDIU, 0, 0, 0, 0, 3, 0, 0);
    drive(C_ADDIU, 0, 0, 0, 0, 3, 0, 0);
    drive(C_SUBU, 3, 3, 1, 1, 7, 0, 0);
    expect_sig(S_FA, 1); expect_sig(S_FB, 1); expect_sig(S_PC, 1);
    drive(C_SUBU, 3, 7, 1, 1, 8, 0, 0);
    expect_sig(S_FA, 2); expect_sig(S_FB, 1);
    drive(C_LBU, 3, 7, 1, 1, 0, 0, 0);
    expect_sig(S_FA, 3); expect_sig(S_FB, 2);

    // register 0: load with dest 0 followed by a reader of r0
    drive(C_SUBU, 0, 0, 1, 1, 10, 0, 0);
    expect_sig(S_PC, 1); expect_sig(S_IFLD, 1); expect_sig(S_FA, 0); expect_sig(S_FB, 0);
    expect_sig(S_EXC, C_LBU); expect_sig(S_EXD, 0);

    // taken branch with delay slot
    drive(C_BGTZ, 0, 0, 0, 0, 0, 0, 0);
    drive(C_ADDIU, 0, 0, 0, 0, 4, 1, 0);
    expect_sig(S_CLR, 1); expect_sig(S_PC, 1); expect_sig(S_FLUSH, 0); expect_sig(S_EXC, C_BGTZ);
    drive(C_NOP, 0, 0, 0, 0, 0, 0, 0);
    expect_sig(S_CLR, 0); expect_sig(S_EXC, C_ADDIU); expect_sig(S_EXD, 4); expect_sig(S_FLUSH, 1);

    // load-use wins over a simultaneous ex_taken
    drive(C_LBU, 0, 0, 0, 0, 5, 0, 0);
    drive(C_SUBU, 5, 0, 1, 0, 6, 1, 0);
    expect_sig(S_PC, 0); expect_sig(S_CLR, 0); expect_sig(S_STALL, 1);
    drive(C_SUBU, 5, 0, 1, 0, 6, 0, 0);
    expect_sig(S_EXC, 0); expect_sig(S_FA, 2); expect_sig(S_STALL, 2); expect_sig(S_FLUSH, 1);

    // freeze for 3 cycles across a load-use hazard
    drive(C_LBU, 0, 0, 0, 0, 12, 0, 0);
    drive(C_SUBU, 12, 0, 1, 0, 13, 0, 1);
    expect_sig(S_PC, 0); expect_sig(S_IFLD, 0); expect_sig(S_CLR, 0); expect_sig(S_EXC, C_LBU); expect_sig(S_EXD, 12);
    drive(C_SUBU, 12, 0, 1, 0, 13, 0, 1);
    expect_sig(S_EXC, C_LBU); expect_sig(S_MEMC, C_SUBU); expect_sig(S_MEMD, 6); expect_sig(S_STALL, 2);
    drive(C_SUBU, 12, 0, 1, 0, 13, 1, 1);
    expect_sig(S_CLR, 0); expect_sig(S_EXD, 12); expect_sig(S_STALL, 2); expect_sig(S_FLUSH, 1);
    drive(C_SUBU, 12, 0, 1, 0, 13, 0, 0);
    expect_sig(S_PC, 0); expect_sig(S_EXC, C_LBU); expect_sig(S_STALL, 2);
    drive(C_SUBU, 12, 0, 1, 0, 13, 0, 0);
    expect_sig(S_EXC, 0); expect_sig(S_MEMC, C_LBU); expect_sig(S_FA, 2); expect_sig(S_PC, 1); expect_sig(S_STALL, 3);

    // stall counter saturation
    drive(C_LBU, 0, 0, 0, 0, 14, 0, 0);
    force dut.stall_cnt_q = 16'hFFFF;
    #1;
    release dut.stall_cnt_q;
    expect_sig(S_STALL, 32'hFFFF);
    drive(C_SUBU, 14, 0, 1, 0, 15, 0, 0);
    expect_sig(S_PC, 0); expect_sig(S_STALL, 32'hFFFF);
    drive(C_NOP, 0, 0, 0, 0, 0, 0, 0);
    expect_sig(S_STALL, 32'hFFFF); expect_sig(S_EXC, 0);

    // reset mid-operation
    drive(C_ADDIU, 0, 0, 0, 0, 9, 0, 0); rst_n = 1'b0;
    drive(C_NOP, 0, 0, 0, 0, 0, 0, 0); rst_n = 1'b1;
    expect_sig(S_EXC, 0); expect_sig(S_MEMC, 0); expect_sig(S_WBC, 0); expect_sig(S_WBD, 0);
    expect_sig(S_STALL, 0); expect_sig(S_FLUSH, 0);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      failures = failures + 1;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
    end
    @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
